// File: rtl/ibex_clic_pkg.sv
// ibex_clic_pkg: shared FSM state type and bus widths for the CLIC controller
package ibex_clic_pkg;
   localparam int unsigned ClicIdWidth   = 12;
   localparam int unsigned ClicPrioWidth = 8;
   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      WAIT_CLAIM
   } clic_ctrl_state_e;
endpackage

// File: rtl/ibex_clic_prio_tree.sv
// ibex_clic_prio_tree: combinational max-priority tree over eligible sources
//   elig_i  - eligible vector
//   prio_i  - per-source priority
//   valid_o - any source eligible
//   idx_o   - winning index (lowest index on ties)
//   prio_o  - winning priority
module ibex_clic_prio_tree
   import ibex_clic_pkg::*;
#(
   parameter int unsigned NumSrc  = 16,
   parameter int unsigned SrcIdxW = $clog2(NumSrc)
) (
   input  logic [NumSrc-1:0]                    elig_i,
   input  logic [NumSrc-1:0][ClicPrioWidth-1:0] prio_i,
   output logic                                 valid_o,
   output logic [SrcIdxW-1:0]                   idx_o,
   output logic [ClicPrioWidth-1:0]             prio_o
);
   localparam int unsigned N2    = 1 << SrcIdxW;
   localparam int unsigned Nodes = 2 * N2 - 1;
   // Heap layout: node k has children 2k+1 (lower indices) and 2k+2, leaves at N2-1+i
   logic                     v  [Nodes];
   logic [ClicPrioWidth-1:0] p  [Nodes];
   logic [SrcIdxW-1:0]       ix [Nodes];
   logic                     l;
   always_comb begin
      l = 1'b0;
      for (int n = 0; n < Nodes; n++) begin
         v[n]  = 1'b0;
         p[n]  = '0;
         ix[n] = '0;
      end
      for (int i = 0; i < NumSrc; i++) begin
         v[N2-1+i]  = elig_i[i];
         p[N2-1+i]  = prio_i[i];
         ix[N2-1+i] = SrcIdxW'(i);
      end
      for (int k = N2 - 2; k >= 0; k--) begin
         // left subtree holds lower indices, so it wins on equal priority
         l     = v[2*k+1] & (~v[2*k+2] | (p[2*k+1] >= p[2*k+2]));
         v[k]  = v[2*k+1] | v[2*k+2];
         p[k]  = l ? p[2*k+1]  : p[2*k+2];
         ix[k] = l ? ix[2*k+1] : ix[2*k+2];
      end
   end
   assign valid_o = v[0];
   assign idx_o   = ix[0];
   assign prio_o  = p[0];
endmodule

// File: rtl/ibex_clic_ctrl.sv
// ibex_clic_ctrl: edge-triggered interrupt sources arbitrated onto the CLIC irq bus
//   irq_src_i           - level sources, rising edge sets pending
//   cfg_*_i             - per-source enable/priority write and pending clear
//   clic_threshold_i    - present only sources with prio above this
//   clic_claim_i        - core-side claim pulse, honoured only in WAIT_CLAIM
//   clic_irq_*_o        - presented request, id and priority
//   pending_o           - pending vector
//   claim_timeout_o     - sticky claim timeout flag
module ibex_clic_ctrl
   import ibex_clic_pkg::*;
#(
   parameter int unsigned NumSrc       = 16,
   parameter int unsigned ClaimTimeout = 15,
   parameter int unsigned SrcIdxW      = $clog2(NumSrc)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NumSrc-1:0]        irq_src_i,
   input  logic                     cfg_we_i,
   input  logic                     cfg_clr_i,
   input  logic [SrcIdxW-1:0]       cfg_idx_i,
   input  logic                     cfg_ie_i,
   input  logic [ClicPrioWidth-1:0] cfg_prio_i,
   input  logic [ClicPrioWidth-1:0] clic_threshold_i,
   input  logic                     clic_claim_i,
   output logic                     clic_irq_o,
   output logic [ClicIdWidth-1:0]   clic_irq_id_o,
   output logic [ClicPrioWidth-1:0] clic_irq_priority_o,
   output logic [NumSrc-1:0]        pending_o,
   output logic                     claim_timeout_o
);
   localparam int unsigned TmrW = $clog2(ClaimTimeout + 1);
   logic [NumSrc-1:0]                    prev_q, pending_q, pending_d, ie_q, clr_mask, elig;
   logic [NumSrc-1:0][ClicPrioWidth-1:0] prio_q;
   logic                                 cfg_ok, win_valid, irq_q, timeout_q;
   logic [SrcIdxW-1:0]                   win_idx, cur_q;
   logic [ClicPrioWidth-1:0]             win_prio, cur_prio_q;
   logic [TmrW-1:0]                      timer_q;
   clic_ctrl_state_e                     state_q;

   assign cfg_ok = 32'(cfg_idx_i) < NumSrc;

   // a rising edge wins over a same-cycle clear
   always_comb begin
      clr_mask  = (cfg_clr_i && cfg_ok) ? (NumSrc'(1) << cfg_idx_i) : '0;
      pending_d = (pending_q & ~clr_mask) | (irq_src_i & ~prev_q);
      for (int i = 0; i < NumSrc; i++) elig[i] = pending_q[i] & ie_q[i] & (prio_q[i] > clic_threshold_i);
   end

   ibex_clic_prio_tree #(.NumSrc(NumSrc), .SrcIdxW(SrcIdxW)) u_tree (
      .elig_i  (elig),
      .prio_i  (prio_q),
      .valid_o (win_valid),
      .idx_o   (win_idx),
      .prio_o  (win_prio)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q    <= '0;
         pending_q <= '0;
         ie_q      <= '0;
         prio_q    <= '0;
      end else begin
         prev_q    <= irq_src_i;
         pending_q <= pending_d;
         if (cfg_we_i && cfg_ok) begin
            ie_q[cfg_idx_i]   <= cfg_ie_i;
            prio_q[cfg_idx_i] <= cfg_prio_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         irq_q      <= 1'b0;
         cur_q      <= '0;
         cur_prio_q <= '0;
         timer_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (win_valid) begin
               cur_q      <= win_idx;
               cur_prio_q <= win_prio;
               irq_q      <= 1'b1;
               state_q    <= PRESENT;
            end
            // only loss of pending/enable on the latched source drops the request
            PRESENT: if (!pending_q[cur_q] || !ie_q[cur_q]) begin
               irq_q   <= 1'b0;
               timer_q <= TmrW'(ClaimTimeout);
               state_q <= WAIT_CLAIM;
            end
            WAIT_CLAIM: begin
               if (clic_claim_i) state_q <= IDLE;
               else if (timer_q == '0) begin
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end else timer_q <= timer_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign clic_irq_o          = irq_q;
   assign clic_irq_id_o       = ClicIdWidth'(cur_q);
   assign clic_irq_priority_o = cur_prio_q;
   assign pending_o           = pending_q;
   assign claim_timeout_o     = timeout_q;
endmodule

// File: tb/tb_ibex_clic_ctrl.sv
// tb_ibex_clic_ctrl: directed checks of arbitration, hand-off and timeout behaviour
module tb_ibex_clic_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] irq_src = '0;
   logic        cfg_we = 1'b0, cfg_clr = 1'b0, cfg_ie = 1'b0, claim = 1'b0;
   logic [3:0]  cfg_idx = '0;
   logic [7:0]  cfg_prio = '0, thr = '0;
   logic        irq, tmo;
   logic [11:0] id;
   logic [7:0]  prio;
   logic [15:0] pend;
   int          total = 0, bad = 0;

   ibex_clic_ctrl #(.NumSrc(16), .ClaimTimeout(15)) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .irq_src_i           (irq_src),
      .cfg_we_i            (cfg_we),
      .cfg_clr_i           (cfg_clr),
      .cfg_idx_i           (cfg_idx),
      .cfg_ie_i            (cfg_ie),
      .cfg_prio_i          (cfg_prio),
      .clic_threshold_i    (thr),
      .clic_claim_i        (claim),
      .clic_irq_o          (irq),
      .clic_irq_id_o       (id),
      .clic_irq_priority_o (prio),
      .pending_o           (pend),
      .claim_timeout_o     (tmo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int idx, input logic ie, input int p);
      cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_ie = ie; cfg_prio = 8'(p);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic clr_src(input int idx);
      cfg_clr = 1'b1; cfg_idx = 4'(idx);
      tick();
      cfg_clr = 1'b0;
   endtask

   task automatic pulse(input logic [15:0] m);
      irq_src = m;
      tick();
      irq_src = '0;
   endtask

   task automatic do_claim();
      claim = 1'b1;
      tick();
      claim = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_irq", 32'(irq), 0);
      chk("rst_id", 32'(id), 0);
      chk("rst_prio", 32'(prio), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_tmo", 32'(tmo), 0);
      rst_n = 1'b1;
      tick();

      // basic present / clear / claim
      cfg_write(3, 1'b1, 5);
      pulse(16'h0008);
      chk("t1_pend", 32'(pend), 32'h8);
      chk("t1_irq_early", 32'(irq), 0);
      tick();
      chk("t1_irq", 32'(irq), 1);
      chk("t1_id", 32'(id), 3);
      chk("t1_prio", 32'(prio), 5);
      clr_src(3);
      chk("t1_irq_hold", 32'(irq), 1);
      tick();
      chk("t1_irq_drop", 32'(irq), 0);
      chk("t1_id_hold", 32'(id), 3);
      do_claim();
      tick();
      chk("t1_pend0", 32'(pend), 0);
      chk("t1_idle", 32'(irq), 0);

      // tie break and ordering
      cfg_write(2, 1'b1, 9);
      cfg_write(7, 1'b1, 9);
      cfg_write(5, 1'b1, 4);
      pulse(16'h00A4);
      chk("t2_pend", 32'(pend), 32'hA4);
      tick();
      chk("t2_id_a", 32'(id), 2);
      chk("t2_prio_a", 32'(prio), 9);
      clr_src(2); tick(); do_claim(); tick();
      chk("t2_irq_b", 32'(irq), 1);
      chk("t2_id_b", 32'(id), 7);
      clr_src(7); tick(); do_claim(); tick();
      chk("t2_id_c", 32'(id), 5);
      chk("t2_prio_c", 32'(prio), 4);
      clr_src(5); tick(); do_claim();

      // threshold is strict
      cfg_write(1, 1'b1, 3);
      thr = 8'd3;
      pulse(16'h0002);
      tick(); tick();
      chk("t3_thr_block", 32'(irq), 0);
      thr = 8'd2;
      tick();
      chk("t3_irq", 32'(irq), 1);
      chk("t3_id", 32'(id), 1);
      thr = 8'd0;
      clr_src(1); tick(); do_claim();

      // no preemption, prio write does not alter presented priority
      cfg_write(4, 1'b1, 10);
      cfg_write(9, 1'b1, 200);
      pulse(16'h0010);
      tick();
      chk("t4_id", 32'(id), 4);
      pulse(16'h0200);
      cfg_write(4, 1'b1, 50);
      tick();
      chk("t4_id_hold", 32'(id), 4);
      chk("t4_prio_hold", 32'(prio), 10);
      chk("t4_pend", 32'(pend), 32'h210);
      clr_src(4); tick();
      chk("t4_drop", 32'(irq), 0);
      do_claim(); tick();
      chk("t4_id_b", 32'(id), 9);
      chk("t4_prio_b", 32'(prio), 200);
      clr_src(9); tick(); do_claim();

      // claim timeout
      cfg_write(6, 1'b1, 7);
      pulse(16'h0040);
      tick();
      chk("t5_id", 32'(id), 6);
      clr_src(6); tick();
      chk("t5_wait", 32'(irq), 0);
      repeat (15) tick();
      chk("t5_tmo_early", 32'(tmo), 0);
      tick();
      chk("t5_tmo", 32'(tmo), 1);
      do_claim(); tick(); tick();
      chk("t5_tmo_sticky", 32'(tmo), 1);
      pulse(16'h0040);
      tick();
      chk("t5_idle_again", 32'(irq), 1);
      clr_src(6); tick(); do_claim();

      // set beats clear on the same index
      irq_src = 16'h0001; cfg_clr = 1'b1; cfg_idx = 4'd0;
      tick();
      irq_src = '0; cfg_clr = 1'b0;
      chk("t6_set_wins", 32'(pend[0]), 1);
      cfg_write(0, 1'b1, 1);
      tick();
      chk("t6_irq", 32'(irq), 1);
      chk("t6_id", 32'(id), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_irq", 32'(irq), 0);
      chk("t6_rst_pend", 32'(pend), 0);
      chk("t6_rst_tmo", 32'(tmo), 0);
      chk("t6_rst_prio", 32'(prio), 0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("t6_post_irq", 32'(irq), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
